// File: rtl/stream_demux_pkg.sv
// ============================================================================
// Module   : stream_demux_pkg
// Brief    : Shared constants, slot state encoding and handshake helper for
//            the stream demultiplexer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef STREAM_DEMUX_HS
`define STREAM_DEMUX_HS(v, r) ((v) & (r))
`endif

package stream_demux_pkg;

    localparam int COUNT_WIDTH = 8;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic int num_ch(input int sel_width);
        return 2 ** sel_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_demux_if.sv
// ============================================================================
// Module   : stream_demux_if
// Brief    : Input stream plus per-channel output streams and counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stream_demux_if #(
    parameter int SEL_WIDTH = 2,
    parameter int WIDTH     = 8
);
    import stream_demux_pkg::*;

    localparam int NUM_CH = num_ch(SEL_WIDTH);

    logic [WIDTH-1:0]              i_data;
    logic [SEL_WIDTH-1:0]          i_sel;
    logic                          i_valid;
    logic                          o_ready;
    logic [NUM_CH*WIDTH-1:0]       o_data;
    logic [NUM_CH-1:0]             o_valid;
    logic [NUM_CH-1:0]             i_ready;
    logic [NUM_CH*COUNT_WIDTH-1:0] o_count;

    // Producer/consumer side that drives the demux.
    modport master (
        output i_data, i_sel, i_valid, i_ready,
        input  o_ready, o_data, o_valid, o_count
    );

    modport slave (
        input  i_data, i_sel, i_valid, i_ready,
        output o_ready, o_data, o_valid, o_count
    );

endinterface

`default_nettype wire

// File: rtl/stream_demux_slot.sv
// ============================================================================
// Module   : stream_demux_slot
// Brief    : One-entry register slice with load/drain logic and an 8-bit
//            delivered-beat counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic                   i_clk,
    input  wire logic                   i_rstn,
    input  wire logic                   i_load,
    input  wire logic [WIDTH-1:0]       i_data,
    input  wire logic                   i_ready,
    output logic                        o_valid,
    output logic [WIDTH-1:0]            o_data,
    output logic [COUNT_WIDTH-1:0]      o_count
);

    slot_state_e             r_state;
    logic [WIDTH-1:0]        r_data;
    logic [COUNT_WIDTH-1:0]  r_count;
    logic                    w_drain;

    assign w_drain = `STREAM_DEMUX_HS(r_state == SLOT_FULL, i_ready);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= SLOT_EMPTY;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            if (w_drain) begin
                r_count <= r_count + COUNT_WIDTH'(1);
            end
            // A load wins over a drain so back-to-back beats keep the slot full.
            if (i_load) begin
                r_state <= SLOT_FULL;
                r_data  <= i_data;
            end else if (w_drain) begin
                r_state <= SLOT_EMPTY;
            end
        end
    end

    assign o_valid = (r_state == SLOT_FULL);
    assign o_data  = r_data;
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/stream_demux.sv
// ============================================================================
// Module   : stream_demux
// Brief    : Routes each input beat to one of 2**SEL_WIDTH buffered output
//            channels selected per beat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int SEL_WIDTH = 2,
    parameter int WIDTH     = 8
) (
    input  wire logic       i_clk,
    input  wire logic       i_rstn,
    stream_demux_if.slave   bus
);

    localparam int NUM_CH = num_ch(SEL_WIDTH);

    logic [NUM_CH-1:0]             w_load;
    logic [NUM_CH-1:0]             w_valid;
    logic [NUM_CH*WIDTH-1:0]       w_data;
    logic [NUM_CH*COUNT_WIDTH-1:0] w_count;
    logic                          w_ready;
    logic                          w_accept;

    // Ready depends only on the addressed slot; held low during reset.
    assign w_ready  = i_rstn & (~w_valid[bus.i_sel] | bus.i_ready[bus.i_sel]);
    assign w_accept = `STREAM_DEMUX_HS(bus.i_valid, w_ready);

    always_comb begin
        w_load             = '0;
        w_load[bus.i_sel]  = w_accept;
    end

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
            stream_demux_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .i_clk   (i_clk),
                .i_rstn  (i_rstn),
                .i_load  (w_load[k]),
                .i_data  (bus.i_data),
                .i_ready (bus.i_ready[k]),
                .o_valid (w_valid[k]),
                .o_data  (w_data[k*WIDTH +: WIDTH]),
                .o_count (w_count[k*COUNT_WIDTH +: COUNT_WIDTH])
            );
        end
    endgenerate

    assign bus.o_ready = w_ready;
    assign bus.o_valid = w_valid;
    assign bus.o_data  = w_data;
    assign bus.o_count = w_count;

endmodule

`default_nettype wire

// File: tb/tb_stream_demux.sv
// ============================================================================
// Module   : tb_stream_demux
// Brief    : Directed self-checking bench for stream_demux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_demux;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_errors;

    stream_demux_if #(.SEL_WIDTH(2), .WIDTH(8)) bus ();

    stream_demux #(.SEL_WIDTH(2), .WIDTH(8)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rstn         = 1'b0;
        bus.i_valid  = 1'b1;
        bus.i_sel    = 2'd0;
        bus.i_data   = 8'h00;
        bus.i_ready  = 4'b1111;

        // Reset held with a valid beat presented.
        tick(); tick();
        check("rst_valid", 64'(bus.o_valid), 64'h0);
        check("rst_count", 64'(bus.o_count), 64'h0);
        check("rst_ready", 64'(bus.o_ready), 64'h0);
        bus.i_valid = 1'b0;
        rstn = 1'b1;
        #1;
        check("rel_ready", 64'(bus.o_ready), 64'h1);

        // Single route to channel 2.
        tick();
        bus.i_sel = 2'd2; bus.i_data = 8'hA5; bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        check("route_valid", 64'(bus.o_valid), 64'b0100);
        check("route_data",  64'(bus.o_data[23:16]), 64'hA5);
        tick();
        check("route_drain", 64'(bus.o_valid), 64'b0000);
        check("route_cnt2",  64'(bus.o_count[23:16]), 64'h1);

        // Back-pressure on channel 1.
        bus.i_ready = 4'b1101;
        bus.i_sel = 2'd1; bus.i_data = 8'h11; bus.i_valid = 1'b1;
        tick();
        check("bp_valid1", 64'(bus.o_valid), 64'b0010);
        check("bp_data1",  64'(bus.o_data[15:8]), 64'h11);
        bus.i_data = 8'h22;
        #1;
        check("bp_ready_lo", 64'(bus.o_ready), 64'h0);
        tick();
        check("bp_hold", 64'(bus.o_data[15:8]), 64'h11);
        bus.i_ready = 4'b1111;
        #1;
        check("bp_ready_hi", 64'(bus.o_ready), 64'h1);
        tick();
        bus.i_valid = 1'b0;
        check("bp_valid2", 64'(bus.o_valid), 64'b0010);
        check("bp_data2",  64'(bus.o_data[15:8]), 64'h22);
        check("bp_cnt1a",  64'(bus.o_count[15:8]), 64'h1);
        tick();
        check("bp_empty",  64'(bus.o_valid), 64'b0000);
        check("bp_cnt1b",  64'(bus.o_count[15:8]), 64'h2);

        // Stalled channel 0 must not block channel 3.
        bus.i_ready = 4'b1110;
        bus.i_sel = 2'd0; bus.i_data = 8'h33; bus.i_valid = 1'b1;
        tick();
        check("ind_valid0", 64'(bus.o_valid), 64'b0001);
        bus.i_sel = 2'd3; bus.i_data = 8'h44;
        #1;
        check("ind_ready", 64'(bus.o_ready), 64'h1);
        tick();
        bus.i_valid = 1'b0;
        check("ind_valid", 64'(bus.o_valid), 64'b1001);
        check("ind_data0", 64'(bus.o_data[7:0]), 64'h33);
        check("ind_data3", 64'(bus.o_data[31:24]), 64'h44);
        tick();
        check("ind_drain3", 64'(bus.o_valid), 64'b0001);
        check("ind_cnt3",   64'(bus.o_count[31:24]), 64'h1);
        bus.i_ready = 4'b1111;
        tick();
        check("ind_drain0", 64'(bus.o_valid), 64'b0000);
        check("ind_cnt0",   64'(bus.o_count[7:0]), 64'h1);

        // 256 back-to-back beats to channel 0; counter goes 1 -> 257 mod 256.
        bus.i_sel = 2'd0; bus.i_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.i_data = 8'(i);
            #1;
            check("str_ready", 64'(bus.o_ready), 64'h1);
            tick();
            check("str_data", 64'(bus.o_data[7:0]), 64'(i));
        end
        bus.i_valid = 1'b0;
        check("str_valid", 64'(bus.o_valid), 64'b0001);
        tick();
        check("str_empty", 64'(bus.o_valid), 64'b0000);
        check("str_wrap",  64'(bus.o_count[7:0]), 64'h1);

        // Asynchronous reset with channels 1 and 2 full.
        bus.i_ready = 4'b0000;
        bus.i_sel = 2'd1; bus.i_data = 8'h55; bus.i_valid = 1'b1;
        tick();
        bus.i_sel = 2'd2; bus.i_data = 8'h66;
        tick();
        bus.i_valid = 1'b0;
        check("ar_full", 64'(bus.o_valid), 64'b0110);
        #2;
        rstn = 1'b0;
        #1;
        check("ar_valid", 64'(bus.o_valid), 64'h0);
        check("ar_count", 64'(bus.o_count), 64'h0);
        check("ar_data",  64'(bus.o_data), 64'h0);
        check("ar_ready", 64'(bus.o_ready), 64'h0);
        #1;
        rstn = 1'b1;
        bus.i_ready = 4'b1111;
        tick();
        check("ar_nostale", 64'(bus.o_valid), 64'h0);
        tick();
        check("ar_cnt", 64'(bus.o_count), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
